// File: rtl/mips_pkg.sv
// Shared fetch-sequencer definitions: word width, pc step, default reset
// vector, the sequencer state encoding and a small alignment helper.
package mips_pkg;

  localparam int          WORD_W               = 32;
  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Instruction addresses must be word aligned.
  function automatic logic misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch-wait watchdog: counts cycles while 'start' is high, restarts from
// zero on 'clear', and flags 'expired' on the TIMEOUT_CYCLES-th counted cycle.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] count_q, count_d;

  assign expired = start && (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Next count: restart on a new request, otherwise advance while waiting.
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (start && !expired)
      count_d = count_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> WAIT -> IDLE, one outstanding imem
// request at a time, with redirect kill, halt drain and sticky error.
// Optional fetch-wait timeout enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] pc_out,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc_out_q, pc_out_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  // kill: the outstanding response belongs to a redirected-away path.
  // hpend: after the outstanding response drains, go to HALT.
  logic              kill_q, kill_d;
  logic              hpend_q, hpend_d;
  logic              wd_expired;

`ifdef FETCH_TIMEOUT_EN
  logic wd_run, wd_clear;
  assign wd_run   = (state_q == S_WAIT);
  assign wd_clear = (state_q == S_IDLE) && (state_d == S_WAIT);

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (wd_run),
    .clear   (wd_clear),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state logic; priority is halt > redirect > ack > stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    req_d    = req_q;
    valid_d  = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    kill_d   = kill_q;
    hpend_d  = hpend_q;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (redirect_valid) begin
          // Redirect consumes this cycle's issue slot regardless of stall.
          if (misaligned(redirect_target)) begin
            err_d    = 1'b1;
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = redirect_target;
          end
        end else if (!stall) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
          kill_d  = 1'b0;
          hpend_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (wd_expired && !imem_ack) begin
          err_d    = 1'b1;
          req_d    = 1'b0;
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          if (halt) begin
            hpend_d = 1'b1;
          end else if (redirect_valid) begin
            if (misaligned(redirect_target)) begin
              err_d   = 1'b1;
              hpend_d = 1'b1;
            end else begin
              pc_d   = redirect_target;
              kill_d = 1'b1;
            end
          end

          if (imem_ack) begin
            req_d  = 1'b0;
            kill_d = 1'b0;
            if (halt || redirect_valid || kill_q || hpend_q) begin
              // Response is drained and dropped.
              state_d  = hpend_d ? S_HALT : S_IDLE;
              halted_d = hpend_d;
            end else begin
              instr_d  = imem_rdata;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_q + PC_INC;
              state_d  = S_IDLE;
            end
          end
        end
      end

      S_HALT: begin
        req_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      addr_q   <= RESET_VECTOR;
      instr_q  <= '0;
      pc_out_q <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      kill_q   <= 1'b0;
      hpend_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      kill_q   <= kill_d;
      hpend_q  <= hpend_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized episodes, all compared each cycle against a transaction-level model.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int          TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid, halt, imem_ack;
  logic [31:0] redirect_target, imem_rdata;
  logic        imem_req, instr_valid, halted, fetch_err;
  logic [31:0] imem_addr, instr, pc_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(RV), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .halt(halt), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .imem_req(imem_req), .imem_addr(imem_addr),
    .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out),
    .halted(halted), .fetch_err(fetch_err)
  );

  // Model: a fetch unit with at most one request in flight.
  logic [31:0] m_pc, m_addr, m_instr, m_pcout;
  bit          m_busy, m_stop, m_discard, m_stop_after, m_err, m_valid;
  int          m_wcnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_addr = RV; m_instr = 0; m_pcout = 0;
    m_busy = 0; m_stop = 0; m_discard = 0; m_stop_after = 0; m_err = 0; m_valid = 0;
    m_wcnt = 0;
  endtask

  // Response for the in-flight request arrived: it is finished either way.
  task automatic model_finish();
    m_busy = 0;
    if (m_stop_after) m_stop = 1;
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [31:0] tg,
                            input bit hl, input bit ak, input logic [31:0] rd);
    bit bad;
    bad     = (tg % 4) != 0;
    m_valid = 0;
    if (m_stop) return;
    if (!m_busy) begin
      if (hl) m_stop = 1;
      else if (rv) begin
        if (bad) begin m_err = 1; m_stop = 1; end
        else m_pc = tg;
      end else if (!st) begin
        m_busy = 1; m_addr = m_pc; m_wcnt = 0;
        m_discard = 0; m_stop_after = 0;
      end
      return;
    end
`ifdef FETCH_TIMEOUT_EN
    if (!ak && m_wcnt == TO - 1) begin
      m_err = 1; m_busy = 0; m_stop = 1;
      return;
    end
`endif
    m_wcnt++;
    if (hl) begin
      m_stop_after = 1;
      if (ak) model_finish();
    end else if (rv) begin
      if (bad) begin m_err = 1; m_stop_after = 1; end
      else begin m_pc = tg; m_discard = 1; end
      if (ak) model_finish();
    end else if (ak) begin
      if (m_discard || m_stop_after) model_finish();
      else begin
        m_instr = rd; m_pcout = m_pc; m_valid = 1;
        m_pc = m_pc + 32'd4;
        m_busy = 0;
      end
    end
  endtask

  task automatic cmp_all();
    chk("imem_req",    {31'b0, imem_req},    {31'b0, m_busy});
    chk("imem_addr",   imem_addr,            m_addr);
    chk("instr",       instr,                m_instr);
    chk("pc_out",      pc_out,               m_pcout);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("halted",      {31'b0, halted},      {31'b0, m_stop});
    chk("fetch_err",   {31'b0, fetch_err},   {31'b0, m_err});
  endtask

  task automatic tick(input bit st, input bit rv, input logic [31:0] tg,
                      input bit hl, input bit ak, input logic [31:0] rd);
    stall = st; redirect_valid = rv; redirect_target = tg;
    halt = hl; imem_ack = ak; imem_rdata = rd;
    model_step(st, rv, tg, hl, ak, rd);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    stall = 0; redirect_valid = 0; redirect_target = 0;
    halt = 0; imem_ack = 0; imem_rdata = 0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    cmp_all();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RV);

    // Sequential fetch 0,4,8 with ack one cycle after each request.
    tick(0,0,0,0,0,0);          chk("seq_addr0", imem_addr, 32'h0);
    chk("seq_req0", {31'b0, imem_req}, 32'd1);
    tick(0,0,0,0,1,32'h0);      chk("seq_instr0", instr, 32'h0);
    chk("seq_v0", {31'b0, instr_valid}, 32'd1);
    tick(0,0,0,0,0,0);          chk("seq_addr4", imem_addr, 32'h4);
    tick(0,0,0,0,1,32'h4);      chk("seq_instr4", instr, 32'h4);
    tick(0,0,0,0,0,0);          chk("seq_addr8", imem_addr, 32'h8);
    tick(0,0,0,0,1,32'h8);      chk("seq_instr8", instr, 32'h8);
    chk("seq_pcout8", pc_out, 32'h8);

    // Redirect in IDLE blocks issue; then redirect while waiting at 0x8.
    tick(0,1,32'h8,0,0,0);      chk("idle_redir_noreq", {31'b0, imem_req}, 32'd0);
    tick(0,0,0,0,0,0);          chk("refetch_addr8", imem_addr, 32'h8);
    tick(0,1,32'h100,0,0,0);    chk("wait_redir_hold", imem_addr, 32'h8);
    tick(0,0,0,0,1,32'hDEAD);   chk("killed_nov", {31'b0, instr_valid}, 32'd0);
    chk("killed_instr", instr, 32'h8);
    tick(0,0,0,0,0,0);          chk("redir_addr100", imem_addr, 32'h100);
    tick(0,0,0,0,1,32'h11);     chk("pcout100", pc_out, 32'h100);

    // Wrap from 0xFFFF_FFFC to 0.
    tick(0,1,32'hFFFF_FFFC,0,0,0);
    tick(0,0,0,0,0,0);          chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick(0,0,0,0,1,32'h22);     chk("wrap_v", {31'b0, instr_valid}, 32'd1);
    tick(0,0,0,0,0,0);          chk("wrap_next", imem_addr, 32'h0);

    // Redirect coincident with ack drops the instruction.
    tick(0,1,32'h200,0,1,32'h33); chk("coinc_nov", {31'b0, instr_valid}, 32'd0);
    chk("coinc_instr", instr, 32'h22);
    tick(0,0,0,0,0,0);          chk("coinc_addr", imem_addr, 32'h200);
    tick(1,0,0,0,1,32'h44);     chk("stall_keeps_v", {31'b0, instr_valid}, 32'd1);
    tick(1,0,0,0,0,0);          chk("stall_noreq", {31'b0, imem_req}, 32'd0);

    // Misaligned redirect halts with error.
    tick(0,1,32'h102,0,0,0);    chk("mis_err", {31'b0, fetch_err}, 32'd1);
    chk("mis_halted", {31'b0, halted}, 32'd1);
    repeat (3) tick(0,0,0,0,1,0);
    chk("mis_noreq", {31'b0, imem_req}, 32'd0);

    // Halt while waiting drains the response first.
    do_reset();
    tick(0,0,0,0,0,0);
    tick(0,0,0,1,0,0);          chk("hdrain_req", {31'b0, imem_req}, 32'd1);
    chk("hdrain_nothalt", {31'b0, halted}, 32'd0);
    tick(0,0,0,0,1,32'h5);      chk("hdrain_halted", {31'b0, halted}, 32'd1);
    chk("hdrain_nov", {31'b0, instr_valid}, 32'd0);

    // Ack never arrives.
    do_reset();
    tick(0,0,0,0,0,0);
    repeat (15) tick(0,0,0,0,0,0);
    chk("to_req15", {31'b0, imem_req}, 32'd1);
    tick(0,0,0,0,0,0);
`ifdef FETCH_TIMEOUT_EN
    chk("to_err", {31'b0, fetch_err}, 32'd1);
    chk("to_halted", {31'b0, halted}, 32'd1);
    repeat (84) tick(0,0,0,0,0,0);
    chk("to_req100", {31'b0, imem_req}, 32'd0);
`else
    chk("noto_req16", {31'b0, imem_req}, 32'd1);
    repeat (84) tick(0,0,0,0,0,0);
    chk("noto_req100", {31'b0, imem_req}, 32'd1);
    chk("noto_err", {31'b0, fetch_err}, 32'd0);
`endif

    // Reset mid-WAIT abandons the request; a stray ack afterwards is ignored.
    do_reset();
    tick(0,1,32'h40,0,0,0);
    tick(0,0,0,0,0,0);          chk("mid_addr", imem_addr, 32'h40);
    do_reset();
    chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
    tick(1,0,0,0,1,32'h77);     chk("stray_nov", {31'b0, instr_valid}, 32'd0);
    tick(0,0,0,0,0,0);          chk("mid_first_addr", imem_addr, RV);

    // Randomized episodes.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        bit st, rv, hl, ak;
        logic [31:0] tg;
        st = ($urandom_range(3) == 0);
        rv = ($urandom_range(9) == 0);
        tg = $urandom;
        if ($urandom_range(19) != 0) tg[1:0] = 2'b00;
        hl = ($urandom_range(199) == 0);
        ak = ($urandom_range(1) == 0);
        tick(st, rv, tg, hl, ak, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
